// File: rtl/i2c_slave_pkg.sv
// rtl/i2c_slave_pkg.sv - shared types and helpers for the multi-digit I2C FND slave
package i2c_slave_pkg;

  typedef enum logic [3:0] {
    IDLE         = 4'd0,
    START        = 4'd1,
    RX_DEV_ADDR  = 4'd2,
    DEV_ADDR_ACK = 4'd3,
    RX_REG_PTR   = 4'd4,
    REG_PTR_ACK  = 4'd5,
    RX_DATA      = 4'd6,
    RX_DATA_ACK  = 4'd7,
    TX_DATA      = 4'd8,
    TX_ACK       = 4'd9,
    WAIT_STOP    = 4'd10
  } state_t;

  localparam int DIG_DP_BIT    = 4;
  localparam int DIG_BLANK_BIT = 7;

  // Common-anode cathode pattern, {g,f,e,d,c,b,a}, low = segment lit.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/fnd_scan_driver.sv
// rtl/fnd_scan_driver.sv - time-multiplexed anode scanner for NUM_DIGITS 7-segment digits
module fnd_scan_driver
  import i2c_slave_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 25000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_DIGITS*8-1:0] digits_i,
  output logic [6:0]              seg_o,
  output logic                    dp_o,
  output logic [NUM_DIGITS-1:0]   an_o
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CW-1:0] div_q, div_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0]    cur_q, cur_d;
  logic          slot_end;
  logic          unused_rsvd;

  assign slot_end = (div_q == CW'(SCAN_DIV - 1));

  // The digit value is captured at slot start so a write lands on the next visit.
  always_comb begin
    div_d = slot_end ? '0 : div_q + 1'b1;
    idx_d = idx_q;
    cur_d = cur_q;
    if (slot_end) begin
      idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
      cur_d = digits_i[{idx_d, 3'b000} +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      idx_q <= '0;
      cur_q <= '0;
    end else begin
      div_q <= div_d;
      idx_q <= idx_d;
      cur_q <= cur_d;
    end
  end

  assign an_o        = ~(NUM_DIGITS'(1) << idx_q);
  assign seg_o       = cur_q[DIG_BLANK_BIT] ? 7'h7F : hex_to_seg(cur_q[3:0]);
  assign dp_o        = cur_q[DIG_BLANK_BIT] | ~cur_q[DIG_DP_BIT];
  assign unused_rsvd = ^cur_q[6:5];

endmodule

// File: rtl/i2c_fnd_mux_slave.sv
// rtl/i2c_fnd_mux_slave.sv - pointer-addressed multi-digit I2C 7-segment slave
// Read-back of the digit registers is built only with FND_READBACK_EN defined.
module i2c_fnd_mux_slave
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h56,
  parameter int         NUM_DIGITS = 4,
  parameter int         CLK_HZ     = 100_000_000,
  parameter int         SCAN_HZ    = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  scl,
  inout  wire                   sda,
  output logic [6:0]            SEG,
  output logic                  DP,
  output logic [NUM_DIGITS-1:0] AN,
  output logic [3:0]            debug_state
);

  localparam int PW       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DIV_RAW  = CLK_HZ / (SCAN_HZ * NUM_DIGITS);
  localparam int SCAN_DIV = (DIV_RAW < 1) ? 1 : DIV_RAW;
`ifdef FND_READBACK_EN
  localparam logic RD_EN = 1'b1;
`else
  localparam logic RD_EN = 1'b0;
`endif

  logic [2:0]    scl_q, sda_q;
  logic          scl_rise, scl_fall, start_det, stop_det, sda_in;
  state_t        state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [PW-1:0] ptr_q, ptr_d, ptr_inc;
  logic          sda_oe_q, sda_oe_d, sda_drive;
  logic          dig_we, byte_done, addr_ok, ptr_ok;
  logic [7:0]    dig_q [NUM_DIGITS];
  logic [NUM_DIGITS*8-1:0] dig_flat;
`ifdef FND_READBACK_EN
  logic          rw_q, rw_d;
  logic [7:0]    tx_q, tx_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], scl};
      sda_q <= {sda_q[1:0], sda};
    end
  end

  assign scl_rise  = scl_q[1] & ~scl_q[2];
  assign scl_fall  = ~scl_q[1] & scl_q[2];
  assign start_det = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
  assign stop_det  = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];
  assign sda_in    = sda_q[1];

  assign byte_done = (bit_cnt_q == 4'd8);
  assign addr_ok   = (shift_q[7:1] == SLAVE_ADDR) && (!shift_q[0] || RD_EN);
  assign ptr_ok    = (32'(shift_q) < 32'(NUM_DIGITS));
  assign ptr_inc   = (ptr_q == PW'(NUM_DIGITS - 1)) ? '0 : ptr_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ptr_q     <= '0;
      sda_oe_q  <= 1'b0;
`ifdef FND_READBACK_EN
      rw_q      <= 1'b0;
      tx_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      sda_oe_q  <= sda_oe_d;
`ifdef FND_READBACK_EN
      rw_q      <= rw_d;
      tx_q      <= tx_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    sda_oe_d  = sda_oe_q;
    dig_we    = 1'b0;
`ifdef FND_READBACK_EN
    rw_d      = rw_q;
    tx_d      = tx_q;
`endif
    if (start_det) begin
      state_d   = START;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else if (stop_det && (state_q != IDLE)) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        START: begin
          state_d   = RX_DEV_ADDR;
          bit_cnt_d = '0;
        end
        RX_DEV_ADDR, RX_REG_PTR, RX_DATA: begin
          if (scl_rise && !byte_done) begin
            shift_d   = {shift_q[6:0], sda_in};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && byte_done) begin
            bit_cnt_d = '0;
            case (state_q)
              RX_DEV_ADDR: begin
                if (addr_ok) begin
                  sda_oe_d = 1'b1;
                  state_d  = DEV_ADDR_ACK;
`ifdef FND_READBACK_EN
                  rw_d     = shift_q[0];
`endif
                end else begin
                  state_d = WAIT_STOP;
                end
              end
              RX_REG_PTR: begin
                if (ptr_ok) begin
                  ptr_d    = shift_q[PW-1:0];
                  sda_oe_d = 1'b1;
                  state_d  = REG_PTR_ACK;
                end else begin
                  state_d = WAIT_STOP;
                end
              end
              default: begin
                sda_oe_d = 1'b1;
                state_d  = RX_DATA_ACK;
              end
            endcase
          end
        end
        DEV_ADDR_ACK: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            state_d   = RX_REG_PTR;
`ifdef FND_READBACK_EN
            // The falling edge that ends the ACK also presents the first read bit.
            if (rw_q) begin
              state_d  = TX_DATA;
              tx_d     = dig_q[ptr_q];
              sda_oe_d = ~dig_q[ptr_q][7];
            end
`endif
          end
        end
        REG_PTR_ACK: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            state_d   = RX_DATA;
          end
        end
        RX_DATA_ACK: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            dig_we    = 1'b1;
            ptr_d     = ptr_inc;
            bit_cnt_d = '0;
            state_d   = RX_DATA;
          end
        end
`ifdef FND_READBACK_EN
        TX_DATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (byte_done) begin
              sda_oe_d = 1'b0;
              ptr_d    = ptr_inc;
              state_d  = TX_ACK;
            end else begin
              tx_d     = {tx_q[6:0], 1'b0};
              sda_oe_d = ~tx_q[6];
            end
          end
        end
        TX_ACK: begin
          // bit_cnt is cleared once the master ACK is seen, arming the next byte.
          if (scl_rise) begin
            if (sda_in) state_d = WAIT_STOP;
            else        bit_cnt_d = '0;
          end else if (scl_fall && (bit_cnt_q == 4'd0)) begin
            state_d  = TX_DATA;
            tx_d     = dig_q[ptr_q];
            sda_oe_d = ~dig_q[ptr_q][7];
          end
        end
`endif
        WAIT_STOP: state_d = WAIT_STOP;
        default:   state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    debug_state = state_q;
    sda_drive   = sda_oe_q && (state_q != IDLE) && (state_q != WAIT_STOP);
  end

  assign sda = sda_drive ? 1'b0 : 1'bz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) dig_q[i] <= '0;
    end else if (dig_we) begin
      dig_q[ptr_q] <= shift_q;
    end
  end

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_pack
    assign dig_flat[gi*8 +: 8] = dig_q[gi];
  end

  fnd_scan_driver #(
    .NUM_DIGITS (NUM_DIGITS),
    .SCAN_DIV   (SCAN_DIV)
  ) u_scan (
    .clk      (clk),
    .rst_n    (rst_n),
    .digits_i (dig_flat),
    .seg_o    (SEG),
    .dp_o     (DP),
    .an_o     (AN)
  );

endmodule

// File: tb/tb_i2c_fnd_mux_slave.sv
// tb/tb_i2c_fnd_mux_slave.sv - directed bench for the multi-digit I2C FND slave
module tb_i2c_fnd_mux_slave;

  localparam int ND = 4;
  localparam int H  = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          scl;
  logic          m_low;
  wire           sda;
  logic [6:0]    SEG;
  logic          DP;
  logic [ND-1:0] AN;
  logic [3:0]    debug_state;

  int total = 0;
  int bad   = 0;
  int drove = 0;
  int snap;
  int n;
  logic a0, a1, a2, a3, a4, a5;
  logic [7:0] rb;
  logic [3:0] cur_an;
  logic [3:0] an_exp [4];

  typedef struct {
    logic [7:0] ptr;
    logic [7:0] data;
    logic [6:0] seg;
    logic       dp;
  } vec_t;
  vec_t vecs [6];

  pullup pu_sda (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  always @(posedge clk) if (!m_low && sda === 1'b0) drove <= drove + 1;

  i2c_fnd_mux_slave #(
    .SLAVE_ADDR (7'h56),
    .NUM_DIGITS (ND),
    .CLK_HZ     (400_000),
    .SCAN_HZ    (1000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .scl         (scl),
    .sda         (sda),
    .SEG         (SEG),
    .DP          (DP),
    .AN          (AN),
    .debug_state (debug_state)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic wait_clk(input int c);
    repeat (c) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_low = 1'b0; wait_clk(H);
    scl = 1'b1;   wait_clk(H);
    m_low = 1'b1; wait_clk(H);
    scl = 1'b0;   wait_clk(2);
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; wait_clk(H);
    scl = 1'b1;   wait_clk(H);
    m_low = 1'b0; wait_clk(H);
  endtask

  task automatic send_bit(input logic b);
    m_low = ~b; wait_clk(H);
    scl = 1'b1; wait_clk(H);
    scl = 1'b0; wait_clk(2);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    m_low = 1'b0; wait_clk(H);
    scl = 1'b1;   wait_clk(H / 2);
    ack = (sda === 1'b0);
    wait_clk(H / 2);
    scl = 1'b0;   wait_clk(2);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b);
    m_low = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wait_clk(H);
      scl = 1'b1; wait_clk(H / 2);
      b = {b[6:0], sda};
      wait_clk(H / 2);
      scl = 1'b0; wait_clk(2);
    end
    m_low = mack; wait_clk(H);
    scl = 1'b1;   wait_clk(H);
    scl = 1'b0;   wait_clk(2);
    m_low = 1'b0;
  endtask

  // Waits for a fresh scan slot of digit k, then checks its cathodes.
  task automatic check_digit(input int k, input logic [6:0] seg, input logic dp, input string nm);
    logic [3:0] an_t;
    int c;
    an_t = ~(4'b0001 << k);
    c = 0;
    while (AN == an_t && c < 1000) begin @(negedge clk); c++; end
    while (AN != an_t && c < 1000) begin @(negedge clk); c++; end
    wait_clk(2);
    if (c >= 1000) begin
      total++;
      bad++;
      $display("FAIL %s: timeout waiting for slot %0d, AN=%b", nm, k, AN);
    end else begin
      chk({nm, "_seg"}, SEG, seg);
      chk({nm, "_dp"}, DP, dp);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'd0, 8'h05, 7'h12, 1'b1};
    vecs[1] = '{8'd1, 8'h1A, 7'h08, 1'b0};
    vecs[2] = '{8'd2, 8'h9C, 7'h7F, 1'b1};
    vecs[3] = '{8'd3, 8'h6D, 7'h21, 1'b1};
    vecs[4] = '{8'd3, 8'h17, 7'h78, 1'b0};
    vecs[5] = '{8'd0, 8'h0E, 7'h06, 1'b1};
    an_exp  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    rst_n = 1'b0; scl = 1'b1; m_low = 1'b0;
    wait_clk(5);
    rst_n = 1'b1;
    chk("rst_an", AN, 4'b1110);
    chk("rst_seg", SEG, 7'h40);
    chk("rst_dp", DP, 1'b1);
    chk("rst_state", debug_state, 4'd0);
    chk("rst_sda", sda, 1'b1);

    for (int s = 1; s <= 4; s++) begin
      cur_an = AN;
      n = 0;
      while (AN == cur_an && n < 1000) begin @(negedge clk); n++; end
      chk($sformatf("slot_len%0d", s), n, 100);
      chk($sformatf("slot_an%0d", s), AN, an_exp[s % 4]);
      chk($sformatf("slot_seg%0d", s), SEG, 7'h40);
      chk($sformatf("slot_dp%0d", s), DP, 1'b1);
    end

    for (int i = 0; i < 6; i++) begin
      i2c_start();
      write_byte(8'hAC, a0);
      write_byte(vecs[i].ptr, a1);
      write_byte(vecs[i].data, a2);
      i2c_stop();
      chk($sformatf("vec%0d_ack", i), {a0, a1, a2}, 3'b111);
      check_digit(int'(vecs[i].ptr), vecs[i].seg, vecs[i].dp, $sformatf("vec%0d", i));
    end

    i2c_start();
    write_byte(8'hAC, a0);
    write_byte(8'h00, a1);
    write_byte(8'h01, a2);
    write_byte(8'h12, a3);
    write_byte(8'h83, a4);
    write_byte(8'h0F, a5);
    i2c_stop();
    chk("burst_ack", {a0, a1, a2, a3, a4, a5}, 6'b111111);
    check_digit(0, 7'h79, 1'b1, "burst_d0");
    check_digit(1, 7'h24, 1'b0, "burst_d1");
    check_digit(2, 7'h7F, 1'b1, "burst_d2");
    check_digit(3, 7'h0E, 1'b1, "burst_d3");

    i2c_start();
    write_byte(8'hAC, a0);
    write_byte(8'h04, a1);
    chk("badptr_addr_ack", a0, 1'b1);
    chk("badptr_nack", a1, 1'b0);
    chk("badptr_state", debug_state, 4'd10);
    i2c_stop();
    chk("badptr_idle", debug_state, 4'd0);
    check_digit(0, 7'h79, 1'b1, "badptr_d0");
    check_digit(3, 7'h0E, 1'b1, "badptr_d3");

    i2c_start();
    write_byte(8'hAC, a0);
    write_byte(8'h02, a1);
    chk("rd_ptr_ack", {a0, a1}, 2'b11);
    i2c_start();
    snap = drove;
    write_byte(8'hAD, a2);
`ifdef FND_READBACK_EN
    chk("rd_addr_ack", a2, 1'b1);
    read_byte(1'b1, rb);
    chk("rd_byte0", rb, 8'h83);
    read_byte(1'b0, rb);
    chk("rd_byte1", rb, 8'h0F);
    chk("rd_nack_state", debug_state, 4'd10);
`else
    chk("rd_addr_nack", a2, 1'b0);
    chk("rd_nack_state", debug_state, 4'd10);
    read_byte(1'b0, rb);
    chk("rd_float", rb, 8'hFF);
    chk("rd_no_drive", drove, snap);
`endif
    i2c_stop();
    chk("rd_idle", debug_state, 4'd0);

    i2c_start();
    write_byte(8'hAC, a0);
    write_byte(8'h03, a1);
    write_byte(8'h05, a2);
    write_byte(8'h07, a3);
    i2c_stop();
    chk("wrap_ack", {a0, a1, a2, a3}, 4'b1111);
    check_digit(3, 7'h12, 1'b1, "wrap_d3");
    check_digit(0, 7'h78, 1'b1, "wrap_d0");

    snap = drove;
    i2c_start();
    write_byte(8'hA0, a0);
    write_byte(8'h55, a1);
    i2c_stop();
    chk("wrong_addr_ack", {a0, a1}, 2'b00);
    chk("wrong_addr_no_drive", drove, snap);
    check_digit(3, 7'h12, 1'b1, "wrong_addr_d3");

    i2c_start();
    write_byte(8'hAC, a0);
    write_byte(8'h01, a1);
    chk("mid_rst_ack", {a0, a1}, 2'b11);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rst_n = 1'b0;
    wait_clk(3);
    chk("mid_rst_an", AN, 4'b1110);
    chk("mid_rst_seg", SEG, 7'h40);
    chk("mid_rst_dp", DP, 1'b1);
    chk("mid_rst_state", debug_state, 4'd0);
    chk("mid_rst_sda", sda, 1'b1);
    m_low = 1'b0;
    scl = 1'b1;
    wait_clk(3);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) check_digit(k, 7'h40, 1'b1, $sformatf("mid_rst_d%0d", k));
    chk("post_rst_state", debug_state, 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_fnd_mux_slave.md
# i2c_fnd_mux_slave

Multi-digit I2C 7-segment slave with a register pointer, auto-increment, per-digit decimal point and blank control, and a time-multiplexed anode scanner. It sits on the shared I2C bus next to the other bus slaves and is the multi-digit successor to the single-digit FND slave. It accepts pointer-addressed writes and, when compiled in, read-back of the digit registers.

## Interface
- SLAVE_ADDR, 7'h56, 7-bit bus address
- NUM_DIGITS, 4, digit count (1..8); pointer width PW = $clog2(NUM_DIGITS), minimum 1
- CLK_HZ, 100_000_000, clk frequency
- SCAN_HZ, 1000, full-display refresh rate
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- scl  in  1  I2C clock
- sda  inout  1  I2C data, open-drain style: drives only 0 or Z
- SEG  out  7  cathodes, active low, {g,f,e,d,c,b,a}
- DP  out  1  decimal point, active low
- AN  out  NUM_DIGITS  anodes, active low, one-hot-zero
- debug_state  out  4  current FSM state encoding

## Operation
- Digit register d[i], 8 bits: [3:0] hex value, [4] dp on, [7] blank, [6:5] reserved (stored, read back).
- Write: [S][addr+W][PTR][D0][D1]...[P]. Data goes to d[ptr]; ptr increments after each data ACK and wraps NUM_DIGITS-1 -> 0.
- Read: [S][addr+R], or a repeated start after the PTR byte. Sends d[ptr] MSB first; ptr increments after each byte; master NACK -> WAIT_STOP.
- PTR >= NUM_DIGITS: NACK, ptr unchanged, go to WAIT_STOP.
- Address mismatch: no drive, go to WAIT_STOP.
- States: IDLE, START, RX_DEV_ADDR, DEV_ADDR_ACK, RX_REG_PTR, REG_PTR_ACK, RX_DATA, RX_DATA_ACK, TX_DATA, TX_ACK, WAIT_STOP.
- START detected in any state (repeated start included) -> START, bit_count = 0.
- STOP in any non-IDLE state -> IDLE, sda released.
- START takes priority over STOP only in the illegal case where both are seen in one cycle; this cannot occur with synced inputs.
- Scanner: digit k is active for SCAN_DIV = CLK_HZ/(SCAN_HZ*NUM_DIGITS) clocks, k counts 0..NUM_DIGITS-1 and wraps. AN[k] = 0 and SEG/DP come from d[k].
- Blank digit: SEG = 7'h7F and DP = 1, but AN still scans.

## Timing
- scl/sda pass through 3-flop synchronizers (reset to 1). Edge and START/STOP detection therefore lag the pins by 2–3 clk.
- Bits are sampled on the synchronized SCL rising edge.
- ACK: sda driven low from the SCL falling edge after bit 8, released on the following falling edge.
- TX: each bit is driven on the SCL falling edge. The first bit is driven at the falling edge that ends the address ACK. The master ACK/NACK is sampled on the 9th rising edge.
- d[ptr] is updated in the clk cycle of the RX_DATA_ACK release edge, and is visible on SEG at the next scan slot for that digit.
- Reset values:
  - state IDLE; sda Z; ptr 0; all d[i] = 8'h00
  - scan index 0; AN = ~1 (digit 0 on); SEG = 7'b1000000 ("0"); DP = 1; debug_state 0
- Reset mid-transfer: immediate return to reset values; a partially received byte is discarded.

## Configuration
- FND_READBACK_EN defined: the read path (TX_DATA, TX_ACK) is built, and addr+R is ACKed.
- Not defined: TX states are absent, addr+R is NACKed -> WAIT_STOP, and sda is never driven during a read.

## Structure
- Package i2c_slave_pkg:
  - state_t enum (4-bit)
  - hex_to_seg function (common-anode table, 0-F)
  - field-position constants for d[i] (DIG_DP_BIT = 4, DIG_BLANK_BIT = 7)
- Sub-module fnd_scan_driver (params NUM_DIGITS, SCAN_DIV): takes the packed digit array and outputs SEG, DP, AN.
- The I2C FSM stays in the top.

## Test plan
- Reset, no traffic -> AN cycles 1110,1101,1011,0111 every 25000 clk; SEG = 7'b1000000 on all; DP = 1.
- Write S,0xAC,0x00,0x01,0x12,0x83,0x0F,P -> all ACKed. Digits read 1, 2 with DP, blank, F. ptr wraps to 0.
- Write S,0xAC,0x04,P with NUM_DIGITS = 4 -> PTR NACKed; no register changes; FSM returns to IDLE on STOP.
- Write S,0xAC,0x02 then repeated S,0xAD, read 2 bytes, ACK then NACK, P (FND_READBACK_EN) -> returns 0x83 then 0x0F.
- Same read without FND_READBACK_EN -> address NACK, and sda stays Z.
- S,0xA0 (wrong address),0x55,P -> no ACK, sda never driven, d unchanged. Assert rst_n mid-data-byte -> all outputs at reset values.
